// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request fields and response/statistics bundle for instr_encoder.
interface instr_encoder_if #(
  parameter int unsigned INST_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned CNT_W     = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic [6:0]           i_opcode;
  logic [4:0]           i_rd;
  logic [4:0]           i_rs1;
  logic [4:0]           i_rs2;
  logic [2:0]           i_funct3;
  logic [6:0]           i_funct7;
  logic [DATA_SIZE-1:0] i_immediate;
  logic                 o_valid;
  logic                 i_ready;
  logic [INST_SIZE-1:0] o_instr;
  logic [1:0]           o_err;
  logic [CNT_W-1:0]     o_instr_count;
  logic [CNT_W-1:0]     o_err_count;

  modport slave (
    input  i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_immediate, i_ready,
    output o_ready, o_valid, o_instr, o_err, o_instr_count, o_err_count
  );

  modport master (
    output i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_immediate, i_ready,
    input  o_ready, o_valid, o_instr, o_err, o_instr_count, o_err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields and an immediate into an instruction word behind a 2-entry FIFO.
// Define ENC_RANGE_CHECK_EN to enable immediate range (10) and alignment (11) errors.
module instr_encoder #(
  parameter int unsigned INST_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  instr_encoder_if.slave bus
);

  typedef enum logic [6:0] {
    LOADS    = 7'b0000011,
    ALC_I    = 7'b0010011,
    JALR     = 7'b1100111,
    STORES   = 7'b0100011,
    BRANCHES = 7'b1100011,
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    JAL      = 7'b1101111,
    ALC_R    = 7'b0110011
  } t_opcode;

  localparam logic [INST_SIZE-1:0] NOP        = INST_SIZE'(32'h0000_0013);
  localparam logic [1:0]           ERR_OK     = 2'b00;
  localparam logic [1:0]           ERR_OPCODE = 2'b01;
`ifdef ENC_RANGE_CHECK_EN
  localparam logic [1:0]           ERR_RANGE  = 2'b10;
  localparam logic [1:0]           ERR_ALIGN  = 2'b11;
`endif

  t_opcode                     op;
  logic signed [DATA_SIZE-1:0] imm_in;
  logic signed [31:0]          imm;
  logic [4:0]                  rd, rs1, rs2;
  logic [2:0]                  f3;
  logic [6:0]                  f7;

  assign op     = t_opcode'(bus.i_opcode);
  assign imm_in = bus.i_immediate;
  assign imm    = 32'(imm_in);
  assign rd     = bus.i_rd;
  assign rs1    = bus.i_rs1;
  assign rs2    = bus.i_rs2;
  assign f3     = bus.i_funct3;
  assign f7     = bus.i_funct7;

  logic [31:0]          word;
  logic                 bad_op;
  logic [1:0]           enc_err;
  logic [INST_SIZE-1:0] enc_instr;
`ifdef ENC_RANGE_CHECK_EN
  logic                 range_bad;
  logic                 misalign;
`endif

  // Field placement per format; checks only exist when range checking is built in
  always_comb begin
    word   = '0;
    bad_op = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    range_bad = 1'b0;
    misalign  = 1'b0;
`endif
    case (op)
      LOADS, JALR, ALC_I: begin
        if (op == ALC_I && (f3 == 3'b001 || f3 == 3'b101)) begin
          word = {f7, imm[4:0], rs1, f3, rd, bus.i_opcode};
`ifdef ENC_RANGE_CHECK_EN
          range_bad = (imm < 32'sd0) || (imm > 32'sd31);
`endif
        end else begin
          word = {imm[11:0], rs1, f3, rd, bus.i_opcode};
`ifdef ENC_RANGE_CHECK_EN
          range_bad = (imm < -32'sd2048) || (imm > 32'sd2047);
`endif
        end
      end
      STORES: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], bus.i_opcode};
`ifdef ENC_RANGE_CHECK_EN
        range_bad = (imm < -32'sd2048) || (imm > 32'sd2047);
`endif
      end
      BRANCHES: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], bus.i_opcode};
`ifdef ENC_RANGE_CHECK_EN
        misalign  = imm[0];
        range_bad = (imm < -32'sd4096) || (imm > 32'sd4094);
`endif
      end
      LUI, AUIPC: begin
        word = {imm[31:12], rd, bus.i_opcode};
`ifdef ENC_RANGE_CHECK_EN
        range_bad = (imm[11:0] != 12'h000);
`endif
      end
      JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, bus.i_opcode};
`ifdef ENC_RANGE_CHECK_EN
        misalign  = imm[0];
        range_bad = (imm < -32'sd1048576) || (imm > 32'sd1048574);
`endif
      end
      ALC_R:   word = {f7, rs2, rs1, f3, rd, bus.i_opcode};
      default: bad_op = 1'b1;
    endcase

    enc_err = ERR_OK;
    if (bad_op)         enc_err = ERR_OPCODE;
`ifdef ENC_RANGE_CHECK_EN
    else if (misalign)  enc_err = ERR_ALIGN;
    else if (range_bad) enc_err = ERR_RANGE;
`endif
    enc_instr = (enc_err == ERR_OK) ? INST_SIZE'(word) : NOP;
  end

  // Two-entry FIFO kept as head (visible word) plus tail
  logic [1:0]           cnt, cnt_nxt;
  logic                 valid_q, ready_q;
  logic [INST_SIZE-1:0] head_instr, tail_instr;
  logic [1:0]           head_err, tail_err;
  logic [CNT_W-1:0]     icnt, ecnt;
  logic                 push, pop, load_head, load_tail, advance;

  always_comb begin
    push      = bus.i_valid && ready_q;
    pop       = valid_q && bus.i_ready;
    cnt_nxt   = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
    load_head = push && ((cnt == 2'd0) || ((cnt == 2'd1) && pop));
    load_tail = push && !load_head;
    advance   = pop && (cnt == 2'd2);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt        <= 2'd0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      head_instr <= '0;
      head_err   <= ERR_OK;
      tail_instr <= '0;
      tail_err   <= ERR_OK;
      icnt       <= '0;
      ecnt       <= '0;
    end else begin
      cnt     <= cnt_nxt;
      valid_q <= (cnt_nxt != 2'd0);
      ready_q <= (cnt_nxt != 2'd2);
      if (load_head) begin
        head_instr <= enc_instr;
        head_err   <= enc_err;
      end else if (advance) begin
        head_instr <= tail_instr;
        head_err   <= tail_err;
      end
      if (load_tail) begin
        tail_instr <= enc_instr;
        tail_err   <= enc_err;
      end
      // Statistics follow words leaving, not words entering
      if (pop) begin
        icnt <= icnt + CNT_W'(1);
        if (head_err != ERR_OK && ecnt != '1) ecnt <= ecnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_ready       = ready_q;
  assign bus.o_instr       = head_instr;
  assign bus.o_err         = head_err;
  assign bus.o_instr_count = icnt;
  assign bus.o_err_count   = ecnt;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a queue-based model.
module tb_instr_encoder;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  instr_encoder_if bus ();

  instr_encoder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef ENC_RANGE_CHECK_EN
  localparam logic [31:0] LUI_BAD_INSTR = 32'h0000_0013;
  localparam logic [31:0] LUI_BAD_ERR   = 32'd2;
  localparam logic [31:0] BEQ3_INSTR    = 32'h0000_0013;
  localparam logic [31:0] BEQ3_ERR      = 32'd3;
  localparam logic [31:0] ERRCNT_A      = 32'd1;
  localparam logic [31:0] ERRCNT_B      = 32'd3;
`else
  localparam logic [31:0] LUI_BAD_INSTR = 32'h1234_52B7;
  localparam logic [31:0] LUI_BAD_ERR   = 32'd0;
  localparam logic [31:0] BEQ3_INSTR    = 32'h0000_0163;
  localparam logic [31:0] BEQ3_ERR      = 32'd0;
  localparam logic [31:0] ERRCNT_A      = 32'd0;
  localparam logic [31:0] ERRCNT_B      = 32'd1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: {err[1:0], word[31:0]} computed with plain arithmetic
  function automatic logic [33:0] model_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input int imm);
    logic [31:0] w, o, d, s1, s2, fn3, fn7, im;
    int e;
    o   = 32'(op);
    d   = 32'(rd) << 7;
    s1  = 32'(rs1) << 15;
    s2  = 32'(rs2) << 20;
    fn3 = 32'(f3) << 12;
    fn7 = 32'(f7) << 25;
    im  = imm;
    e   = 0;
    w   = '0;
    case (op)
      7'h03, 7'h67, 7'h13: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = fn7 | ((im & 32'h1F) << 20) | s1 | fn3 | d | o;
          if (imm < 0 || imm > 31) e = 2;
        end else begin
          w = ((im & 32'hFFF) << 20) | s1 | fn3 | d | o;
          if (imm < -2048 || imm > 2047) e = 2;
        end
      end
      7'h23: begin
        w = (((im >> 5) & 32'h7F) << 25) | s2 | s1 | fn3 | ((im & 32'h1F) << 7) | o;
        if (imm < -2048 || imm > 2047) e = 2;
      end
      7'h63: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | s2 | s1 | fn3
          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
        if (im[0]) e = 3;
        else if (imm < -4096 || imm > 4094) e = 2;
      end
      7'h37, 7'h17: begin
        w = (im & 32'hFFFF_F000) | d | o;
        if ((im & 32'hFFF) != 0) e = 2;
      end
      7'h6F: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | o;
        if (im[0]) e = 3;
        else if (imm < -1048576 || imm > 1048574) e = 2;
      end
      7'h33: w = fn7 | s2 | s1 | fn3 | d | o;
      default: e = 1;
    endcase
`ifndef ENC_RANGE_CHECK_EN
    if (e != 1) e = 0;
`endif
    if (e != 0) w = 32'h13;
    return {2'(e), w};
  endfunction

  // Model state: words in flight plus statistics
  logic [33:0] q[$];
  logic [15:0] m_icnt = '0;
  logic [15:0] m_ecnt = '0;

  always @(posedge clk or posedge rst) begin
    logic        acc, pp;
    logic [33:0] enc;
    if (rst) begin
      q.delete();
      m_icnt = '0;
      m_ecnt = '0;
    end else begin
      acc = bus.i_valid && (q.size() < 2);
      pp  = (q.size() != 0) && bus.i_ready;
      enc = model_encode(bus.i_opcode, bus.i_rd, bus.i_rs1, bus.i_rs2, bus.i_funct3,
                         bus.i_funct7, int'($signed(bus.i_immediate)));
      if (pp) begin
        m_icnt = m_icnt + 16'd1;
        if (q[0][33:32] != 2'b00 && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
        q.delete(0);
      end
      if (acc) q.push_back(enc);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("o_valid", 32'(bus.o_valid), 32'(q.size() != 0));
      chk("o_ready", 32'(bus.o_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
        chk("o_instr", bus.o_instr, q[0][31:0]);
        chk("o_err", 32'(bus.o_err), 32'(q[0][33:32]));
      end
      chk("o_instr_count", 32'(bus.o_instr_count), 32'(m_icnt));
      chk("o_err_count", 32'(bus.o_err_count), 32'(m_ecnt));
    end
  end

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input int imm);
    bus.i_opcode    = op;
    bus.i_rd        = rd;
    bus.i_rs1       = rs1;
    bus.i_rs2       = rs2;
    bus.i_funct3    = f3;
    bus.i_funct7    = f7;
    bus.i_immediate = 32'(imm);
  endtask

  // Offer one request and return 2 time units after the accepting edge
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input int imm);
    int n;
    drive(op, rd, rs1, rs2, f3, f7, imm);
    bus.i_valid = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.o_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: o_ready=%0b expected 1 within 50 cycles", bus.o_ready);
    end
    @(posedge clk); #2;
    bus.i_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic int rand_imm();
    int bnd[12];
    bnd = '{-2048, 2047, 2048, -2049, 31, 32, -4096, 4094, 4096, -1048576, 1048574, 1048576};
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 8191)) - 4096;
      1:       return int'($urandom_range(0, 63)) - 16;
      2:       return int'($urandom);
      3:       return int'($urandom & 32'hFFFF_F000);
      default: return bnd[$urandom_range(0, 11)] + int'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    logic [33:0] m;
    logic [6:0]  ops[9];
    logic [6:0]  op;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drive(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0);

    // Pin the reference model on known encodings
    m = model_encode(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -1);
    chk("model_addi", m[31:0], 32'hFFF0_0093);
    m = model_encode(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 8);
    chk("model_sw", m[31:0], 32'h0021_A423);
    m = model_encode(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048);
    chk("model_jal", m[31:0], 32'h0010_00EF);
    m = model_encode(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 0);
    chk("model_badop", 32'(m[33:32]), 32'd1);

    #3;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_instr", bus.o_instr, 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_icnt", 32'(bus.o_instr_count), 32'd0);
    chk("rst_ecnt", 32'(bus.o_err_count), 32'd0);
    step();
    rst = 1'b0;

    // Single encodes with the consumer always ready
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -1);
    chk("addi_valid", 32'(bus.o_valid), 32'd1);
    chk("addi_instr", bus.o_instr, 32'hFFF0_0093);
    chk("addi_err", 32'(bus.o_err), 32'd0);
    step();
    chk("addi_icnt", 32'(bus.o_instr_count), 32'd1);

    send(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 8);
    chk("sw_instr", bus.o_instr, 32'h0021_A423);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048);
    chk("jal_instr", bus.o_instr, 32'h0010_00EF);

    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    chk("lui_instr", bus.o_instr, 32'h1234_52B7);
    chk("lui_err", 32'(bus.o_err), 32'd0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    chk("lui_bad_instr", bus.o_instr, LUI_BAD_INSTR);
    chk("lui_bad_err", 32'(bus.o_err), LUI_BAD_ERR);
    step();
    chk("lui_bad_ecnt", 32'(bus.o_err_count), ERRCNT_A);
    chk("five_icnt", 32'(bus.o_instr_count), 32'd5);

    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 3);
    chk("beq3_instr", bus.o_instr, BEQ3_INSTR);
    chk("beq3_err", 32'(bus.o_err), BEQ3_ERR);
    send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 0);
    chk("badop_instr", bus.o_instr, 32'h0000_0013);
    chk("badop_err", 32'(bus.o_err), 32'd1);
    step();
    chk("badop_ecnt", 32'(bus.o_err_count), ERRCNT_B);

    // Back-pressure: two accepted, third held off until a pop
    bus.i_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 7);
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 9);
    bus.i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", 32'(bus.o_ready), 32'd0);
      chk("stall_instr", bus.o_instr, 32'h0050_0093);
      step();
    end
    bus.i_ready = 1'b1;
    step();
    chk("drain_b", bus.o_instr, 32'h0070_0113);
    chk("drain_ready", 32'(bus.o_ready), 32'd1);
    step();
    chk("drain_c", bus.o_instr, 32'h0090_0193);
    bus.i_valid = 1'b0;
    step();

    // Asynchronous reset with a full FIFO
    bus.i_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 7);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_ready", 32'(bus.o_ready), 32'd1);
    chk("arst_icnt", 32'(bus.o_instr_count), 32'd0);
    chk("arst_ecnt", 32'(bus.o_err_count), 32'd0);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -1);
    chk("post_rst_instr", bus.o_instr, 32'hFFF0_0093);
    step();
    chk("post_rst_icnt", 32'(bus.o_instr_count), 32'd1);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      drive(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
            rand_imm());
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
